// File: rtl/conv_phase_center_loader.sv
// Sequences centre-RAM writes for conv_phase: single-entry loads, full-bank clears and
// frame-aligned bank swaps, decoded from rising edges of the software command word.
module conv_phase_center_loader #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 20,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              user_clk,
   input  logic              user_rst,
   input  logic [31:0]       cmd_word,
   input  logic              sync_in,
   output logic              ram_we,
   output logic              ram_bank,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              bank_sel,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  load_count
);

   localparam int unsigned ChHi = ADDR_W + DATA_W - 1;
   localparam logic [ADDR_W-1:0] LastAddr = '1;

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StSweep,
      StWaitSync,
      StFinish
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       cmd_q;
   logic [2:0]        cmd_p_q;
   logic              armed_q;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              bank_q, bank_d;
   logic              is_load_q, is_load_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              load_e, clr_e, swap_e, any_e;

   // Bits between the payload and the flag field carry no meaning.
   if (ADDR_W + DATA_W < 29) begin : g_unused
      logic unused_cmd;
      assign unused_cmd = ^cmd_q[28:ADDR_W+DATA_W];
   end

   // Command capture is deliberately not reset, so a bit held high through reset is already
   // in cmd_q at release and can never look like an edge.
   always_ff @(posedge user_clk) begin
      cmd_q <= cmd_word;
   end

   // Previous-cycle flags and the arm bit that masks the first cycle after reset.
   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         cmd_p_q <= '0;
         armed_q <= 1'b0;
      end else begin
         cmd_p_q <= cmd_q[31:29];
         armed_q <= 1'b1;
      end
   end

   assign load_e = cmd_q[31] & ~cmd_p_q[2] & armed_q;
   assign clr_e  = cmd_q[30] & ~cmd_p_q[1] & armed_q;
   assign swap_e = cmd_q[29] & ~cmd_p_q[0] & armed_q;
   assign any_e  = load_e | clr_e | swap_e;

   // State and datapath registers.
   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         data_q    <= '0;
         bank_q    <= 1'b0;
         is_load_q <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         bank_q    <= bank_d;
         is_load_q <= is_load_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
      end
   end

   // Command decode, sequencing and write-port control.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      data_d    = data_q;
      bank_d    = bank_q;
      is_load_d = is_load_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      ram_we    = 1'b0;
      done      = 1'b0;

      if (state_q != StIdle && any_e) begin
         err_d = 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (clr_e) begin
               state_d   = StSweep;
               addr_d    = '0;
               data_d    = '0;
               is_load_d = 1'b0;
               if (load_e || swap_e) err_d = 1'b1;
            end else if (load_e) begin
               state_d   = StWrite;
               addr_d    = cmd_q[ChHi:DATA_W];
               data_d    = cmd_q[DATA_W-1:0];
               is_load_d = 1'b1;
               if (swap_e) err_d = 1'b1;
            end else if (swap_e) begin
               state_d   = StWaitSync;
               is_load_d = 1'b0;
            end
         end
         StWrite: begin
            ram_we  = 1'b1;
            state_d = StFinish;
         end
         StSweep: begin
            ram_we = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
            if (addr_q == LastAddr) state_d = StFinish;
         end
         StWaitSync: begin
            if (sync_in) begin
               bank_d  = ~bank_q;
               state_d = StFinish;
            end
         end
         StFinish: begin
            done    = 1'b1;
            state_d = StIdle;
            if (is_load_q) cnt_d = cnt_q + CNT_W'(1);
         end
         default: state_d = StIdle;
      endcase
   end

   assign ram_addr   = addr_q;
   assign ram_data   = data_q;
   assign bank_sel   = bank_q;
   assign ram_bank   = ~bank_q;
   assign busy       = (state_q != StIdle);
   assign err        = err_q;
   assign load_count = cnt_q;

endmodule

// File: tb/tb_conv_phase_center_loader.sv
// Bench for conv_phase_center_loader: expected RAM writes are queued as each command is issued
// and checked by a monitor whenever ram_we is seen.
module tb_conv_phase_center_loader;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 20;
   localparam int CNT_W  = 16;
   localparam int NCHAN  = 256;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [31:0]       cmd = 32'h0;
   logic              sync = 1'b0;
   logic              ram_we, ram_bank, bank_sel, busy, done, err;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_data;
   logic [CNT_W-1:0]  load_count;

   typedef struct packed {
      logic              bank;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  checks = 0;
   int  errors = 0;

   conv_phase_center_loader #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
   ) dut (
      .user_clk  (clk),
      .user_rst  (rst),
      .cmd_word  (cmd),
      .sync_in   (sync),
      .ram_we    (ram_we),
      .ram_bank  (ram_bank),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .bank_sel  (bank_sel),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .load_count(load_count)
   );

   always #5 clk = ~clk;

   // Scoreboard: every observed write must match the oldest expected write.
   always @(negedge clk) begin
      if (ram_we === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected got bank %0d addr %0h data %0h, required no write",
                     ram_bank, ram_addr, ram_data);
         end else begin
            mon_e = exp_q.pop_front();
            if ({ram_bank, ram_addr, ram_data} !== mon_e) begin
               errors++;
               $display("FAIL write_data got bank %0d addr %0h data %0h, required %0d %0h %0h",
                        ram_bank, ram_addr, ram_data, mon_e.bank, mon_e.addr, mon_e.data);
            end
         end
      end
   end

   task automatic drive_cmd(input logic [31:0] v);
      @(posedge clk);
      #1 cmd = v;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_sweep(input logic bank, input int last);
      for (int i = 0; i <= last; i++) exp_q.push_back({bank, ADDR_W'(i), DATA_W'(0)});
   endtask

   task automatic wait_done(input string name, input int bound);
      bit seen = 0;
      for (int k = 0; k < bound && !seen; k++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_done got no done pulse, required one within %0d cycles", name, bound);
      end
   endtask

   task automatic check_queue_empty(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_writes got %0d writes missing, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_idle_outputs(input string name);
      checks++;
      if ({ram_we, ram_addr, ram_data, bank_sel, busy, done, err, load_count} !== '0 ||
          ram_bank !== 1'b1) begin
         errors++;
         $display("FAIL %s_outputs got we %0b addr %0h data %0h bank_sel %0b ram_bank %0b busy %0b done %0b err %0b cnt %0d, required all 0 with ram_bank 1",
                  name, ram_we, ram_addr, ram_data, bank_sel, ram_bank, busy, done, err,
                  load_count);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cmd = 32'h8000_0000;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({ram_we, err, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_held_load cycle %0d got we %0b err %0b busy %0b, required 000",
                     i, ram_we, err, busy);
         end
      end
      check_idle_outputs("reset");
      drive_cmd(32'h0);
      idle_cycles(3);
   endtask

   task automatic test_load();
      drive_cmd(32'h8120_ABCD);
      exp_q.push_back({1'b1, 8'h12, 20'h0ABCD});
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (ram_we !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL load_cycle1 got we %0b busy %0b, required 0 0", ram_we, busy);
      end
      @(negedge clk);
      checks++;
      if (ram_we !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL load_cycle2 got we %0b busy %0b, required 1 1", ram_we, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || ram_we !== 1'b0) begin
         errors++;
         $display("FAIL load_cycle3 got done %0b we %0b, required 1 0", done, ram_we);
      end
      @(negedge clk);
      checks++;
      if (load_count !== 16'd1 || done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL load_count got %0d done %0b busy %0b, required 1 0 0",
                  load_count, done, busy);
      end
      check_queue_empty("load");
      drive_cmd(32'h0);
      idle_cycles(3);
   endtask

   task automatic test_clear();
      int busy_n = 0;
      bit seen = 0;
      drive_cmd(32'h4000_0000);
      push_sweep(1'b1, NCHAN - 1);
      for (int k = 0; k < 400 && !seen; k++) begin
         @(negedge clk);
         if (busy === 1'b1) busy_n++;
         if (done === 1'b1) seen = 1;
      end
      checks++;
      if (!seen || busy_n < 257) begin
         errors++;
         $display("FAIL clear_busy got done %0b busy cycles %0d, required 1 and >= 257",
                  seen, busy_n);
      end
      check_queue_empty("clear");
      @(negedge clk);
      checks++;
      if (ram_addr !== 8'h00 || busy !== 1'b0 || load_count !== 16'd1) begin
         errors++;
         $display("FAIL clear_exit got addr %0h busy %0b cnt %0d, required 0 0 1",
                  ram_addr, busy, load_count);
      end
      drive_cmd(32'h0);
      idle_cycles(3);
   endtask

   task automatic test_swap();
      drive_cmd(32'h2000_0000);
      sync = 1'b1;                // seen only while still idle: must be ignored
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 sync = 1'b0;
      idle_cycles(3);
      sync = 1'b1;
      @(negedge clk);
      checks++;
      if (bank_sel !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL swap_wait got bank_sel %0b busy %0b done %0b, required 0 1 0",
                  bank_sel, busy, done);
      end
      @(posedge clk);
      #1 sync = 1'b0;
      @(negedge clk);
      checks++;
      if (bank_sel !== 1'b1 || ram_bank !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL swap_toggle got bank_sel %0b ram_bank %0b done %0b, required 1 0 1",
                  bank_sel, ram_bank, done);
      end
      drive_cmd(32'h0);
      idle_cycles(3);
   endtask

   task automatic test_collision();
      drive_cmd(32'hC000_0000);
      push_sweep(1'b0, NCHAN - 1);
      idle_cycles(20);
      cmd = 32'h4000_0000;
      idle_cycles(3);
      cmd = 32'hC000_0000;      // LOAD edge while sweeping
      wait_done("collision", 400);
      idle_cycles(5);
      checks++;
      if (err !== 1'b1 || load_count !== 16'd1 || bank_sel !== 1'b1) begin
         errors++;
         $display("FAIL collision_state got err %0b cnt %0d bank_sel %0b, required 1 1 1",
                  err, load_count, bank_sel);
      end
      check_queue_empty("collision");
      drive_cmd(32'h0);
      idle_cycles(3);
   endtask

   task automatic test_reset_mid();
      bit seen = 0;
      drive_cmd(32'h4000_0000);
      push_sweep(1'b0, 100);
      for (int k = 0; k < 400 && !seen; k++) begin
         @(negedge clk);
         if (ram_we === 1'b1 && ram_addr === 8'd100) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL rstmid_reach got no write to addr 100, required one");
      end
      rst = 1'b1;
      @(negedge clk);
      check_idle_outputs("rstmid");
      idle_cycles(2);
      rst = 1'b0;
      idle_cycles(6);
      check_queue_empty("rstmid_abort");
      cmd = 32'h0;
      idle_cycles(3);
      cmd = 32'h4000_0000;
      push_sweep(1'b1, NCHAN - 1);
      wait_done("rstmid_restart", 400);
      check_queue_empty("rstmid_restart");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_load();
      test_clear();
      test_swap();
      test_collision();
      test_reset_mid();
      idle_cycles(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
